// File: rtl/regfile_pkg.sv
// Shared defaults and sizing helpers for the multiport register file.
// The top level and the pending-write scoreboard both import this package.
package regfile_pkg;

   localparam int unsigned DefDataW = 32;
   localparam int unsigned DefAddrW = 5;
   localparam int unsigned DefNumRd = 2;

   function automatic int unsigned depth_of(input int unsigned addr_w);
      return 32'd1 << addr_w;
   endfunction

   // One extra bit so that a completely pending file is representable.
   function automatic int unsigned cnt_width(input int unsigned addr_w);
      return addr_w + 32'd1;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one pending bit per register plus a registered
// population count, which moves by at most one step in each direction per cycle.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_W   = DefAddrW,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           iss_en,
   input  logic [ADDR_W-1:0]              iss_addr,
   input  logic                           wr_en,
   input  logic [ADDR_W-1:0]              wr_addr,
   output logic [depth_of(ADDR_W)-1:0]    pending,
   output logic [cnt_width(ADDR_W)-1:0]   pending_cnt
);

   localparam int unsigned DEPTH  = depth_of(ADDR_W);
   localparam int unsigned CNT_W  = cnt_width(ADDR_W);
   localparam bit          ZeroEn = (ZERO_REG != 0);

   logic [DEPTH-1:0] pending_q, pending_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             iss_ok, wr_ok, set_new, clr_old;

   always_comb begin
      iss_ok    = iss_en & ~(ZeroEn & (iss_addr == '0));
      wr_ok     = wr_en & ~(ZeroEn & (wr_addr == '0));

      // The issue is applied after the clear, so the new producer wins on a collision.
      pending_d = pending_q;
      if (wr_ok) begin
         pending_d[wr_addr] = 1'b0;
      end
      if (iss_ok) begin
         pending_d[iss_addr] = 1'b1;
      end

      set_new = iss_ok & ~pending_q[iss_addr];
      clr_old = wr_ok & pending_q[wr_addr] & ~(iss_ok & (iss_addr == wr_addr));
      cnt_d   = cnt_q + CNT_W'(set_new) - CNT_W'(clr_old);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         cnt_q     <= '0;
      end else begin
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
      end
   end

   assign pending     = pending_q;
   assign pending_cnt = cnt_q;

endmodule

// File: rtl/multiport_register_file.sv
// General-purpose register file: NUM_RD combinational read ports with same-cycle
// write bypass, one write-back port and an integrated pending-write scoreboard.
module multiport_register_file
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DefDataW,
   parameter int unsigned ADDR_W   = DefAddrW,
   parameter int unsigned NUM_RD   = DefNumRd,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_pending,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       iss_en,
   input  logic [ADDR_W-1:0]          iss_addr,
   output logic [ADDR_W:0]            pending_cnt
);

   localparam int unsigned DEPTH  = depth_of(ADDR_W);
   localparam bit          ZeroEn = (ZERO_REG != 0);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  pending;
   logic              wr_ok;

   regfile_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk         (clk),
      .rst_n       (rst_n),
      .iss_en      (iss_en),
      .iss_addr    (iss_addr),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .pending     (pending),
      .pending_cnt (pending_cnt)
   );

   always_comb begin
      wr_ok = wr_en & ~(ZeroEn & (wr_addr == '0));
      mem_d = mem_q;
      if (wr_ok) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              is_zero;
      logic              hit;

      assign addr    = rd_addr[p*ADDR_W +: ADDR_W];
      assign is_zero = ZeroEn & (addr == '0);
      assign hit     = wr_en & (wr_addr == addr);

      // Zero register outranks the bypass; the bypass outranks storage.
      assign rd_data[p*DATA_W +: DATA_W] = is_zero ? '0      :
                                           hit     ? wr_data :
                                                     mem_q[addr];
      // A write-back in this cycle already satisfies the consumer.
      assign rd_pending[p] = ~is_zero & pending[addr] & ~hit;
   end

endmodule

// File: tb/tb_multiport_register_file.sv
// Randomised scoreboard bench for multiport_register_file (4 read ports, r0 hardwired).
module tb_multiport_register_file;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NR    = 4;
   localparam int DEPTH = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NR*AW-1:0]  rd_addr = '0;
   logic [NR*DW-1:0]  rd_data;
   logic [NR-1:0]     rd_pending;
   logic              wr_en = 1'b0;
   logic [AW-1:0]     wr_addr = '0;
   logic [DW-1:0]     wr_data = '0;
   logic              iss_en = 1'b0;
   logic [AW-1:0]     iss_addr = '0;
   logic [AW:0]       pending_cnt;

   always #5 clk = ~clk;

   multiport_register_file #(
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .NUM_RD   (NR),
      .ZERO_REG (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_pending  (rd_pending),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .iss_en      (iss_en),
      .iss_addr    (iss_addr),
      .pending_cnt (pending_cnt)
   );

   typedef struct {
      logic [NR*DW-1:0] data;
      logic [NR-1:0]    pend;
      logic [AW:0]      cnt;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_pend [DEPTH];
   int            checks = 0;
   int            failures = 0;

   task automatic chk(input string name, input int idx, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%h exp=%h t=%0t", name, idx, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i]  = '0;
         m_pend[i] = 1'b0;
      end
   endtask

   function automatic logic [NR*AW-1:0] ra4(input int a0, input int a1, input int a2,
                                            input int a3);
      return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
   endfunction

   // Drive one cycle of stimulus, queue the expected outputs, then advance the model.
   task automatic apply(input bit rs, input bit we, input int wa, input logic [DW-1:0] wd,
                        input bit ie, input int ia, input logic [NR*AW-1:0] ra);
      exp_t          e;
      int            n;
      int            a;
      @(posedge clk);
      #1;
      rst_n    = rs;
      wr_en    = we;
      wr_addr  = AW'(wa);
      wr_data  = wd;
      iss_en   = ie;
      iss_addr = AW'(ia);
      rd_addr  = ra;
      if (!rs) model_reset();
      for (int p = 0; p < NR; p++) begin
         a = int'(ra[p*AW +: AW]);
         if (a == 0)                 e.data[p*DW +: DW] = '0;
         else if (we && (wa == a))   e.data[p*DW +: DW] = wd;
         else                        e.data[p*DW +: DW] = m_mem[a];
         e.pend[p] = (a != 0) && m_pend[a] && !(we && (wa == a));
      end
      n = 0;
      for (int i = 0; i < DEPTH; i++) n += int'(m_pend[i]);
      e.cnt = n[AW:0];
      sb_q.push_back(e);
      if (rs) begin
         if (we && (wa != 0)) begin
            m_mem[wa]  = wd;
            m_pend[wa] = 1'b0;
         end
         if (ie && (ia != 0)) m_pend[ia] = 1'b1;
      end
   endtask

   task automatic rd(input logic [NR*AW-1:0] ra);
      apply(1'b1, 1'b0, 0, '0, 1'b0, 0, ra);
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         for (int p = 0; p < NR; p++) begin
            chk("rd_data", p, rd_data[p*DW +: DW], mon_e.data[p*DW +: DW]);
            chk("rd_pending", p, DW'(rd_pending[p]), DW'(mon_e.pend[p]));
         end
         chk("pending_cnt", 0, DW'(pending_cnt), DW'(mon_e.cnt));
      end
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);

      rd(ra4(0, 5, 7, 31));
      // Reset mid-operation wipes stored data and pending state.
      apply(1'b1, 1'b1, 5, 32'hDEADBEEF, 1'b1, 2, ra4(5, 2, 0, 1));
      rd(ra4(5, 2, 3, 0));
      apply(1'b0, 1'b0, 0, '0, 1'b0, 0, ra4(5, 2, 3, 0));
      apply(1'b0, 1'b1, 6, 32'h55, 1'b1, 6, ra4(5, 2, 1, 3));
      rd(ra4(6, 5, 2, 0));

      // Bypass, then storage.
      apply(1'b1, 1'b1, 7, 32'h12345678, 1'b0, 0, ra4(7, 7, 0, 1));
      rd(ra4(7, 1, 2, 3));

      // Zero register.
      apply(1'b1, 1'b1, 0, 32'hFFFFFFFF, 1'b1, 0, ra4(0, 0, 0, 0));
      rd(ra4(0, 7, 0, 0));

      // Issue / re-issue / write-back.
      apply(1'b1, 1'b0, 0, '0, 1'b1, 3, ra4(3, 4, 0, 0));
      apply(1'b1, 1'b0, 0, '0, 1'b1, 4, ra4(3, 4, 0, 0));
      apply(1'b1, 1'b0, 0, '0, 1'b1, 3, ra4(3, 4, 0, 0));
      apply(1'b1, 1'b1, 3, 32'hA5A5A5A5, 1'b0, 0, ra4(3, 4, 3, 0));
      rd(ra4(3, 4, 0, 7));

      // Same-address issue and write-back of a pending register.
      apply(1'b1, 1'b0, 0, '0, 1'b1, 9, ra4(9, 0, 0, 0));
      apply(1'b1, 1'b1, 9, 32'h00C0FFEE, 1'b1, 9, ra4(9, 9, 4, 0));
      rd(ra4(9, 4, 3, 0));

      // Different addresses in one cycle: net 0, +1, -1.
      apply(1'b1, 1'b1, 4, 32'h44, 1'b1, 10, ra4(4, 10, 9, 0));
      apply(1'b1, 1'b1, 12, 32'h1, 1'b1, 11, ra4(10, 11, 12, 9));
      apply(1'b1, 1'b1, 10, 32'h2, 1'b1, 11, ra4(10, 11, 12, 9));
      rd(ra4(10, 11, 12, 9));

      // Sweep: fill the scoreboard, then drain it with write-backs.
      for (int i = 1; i < DEPTH; i++) begin
         apply(1'b1, 1'b0, 0, '0, 1'b1, i, ra4(i, $urandom_range(0, 31),
                                              $urandom_range(0, 31), i - 1));
      end
      for (int i = 1; i < DEPTH; i++) begin
         apply(1'b1, 1'b1, i, $urandom, 1'b0, 0, ra4(i, i - 1, $urandom_range(0, 31),
                                                      (i + 1) % DEPTH));
      end
      for (int i = 0; i < DEPTH / NR; i++) begin
         rd(ra4(4 * i, 4 * i + 1, 4 * i + 2, 4 * i + 3));
      end

      // Random traffic with occasional mid-run resets.
      for (int k = 0; k < 500; k++) begin
         apply(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)),
               $urandom_range(0, 31), $urandom, 1'($urandom_range(0, 1)),
               $urandom_range(0, 31),
               ra4($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31)));
      end
      rd(ra4(1, 2, 3, 4));

      for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(posedge clk);
      @(posedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d pending entries exp=0", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
